// File: rtl/bttn_debounce.sv
// Push-button conditioner: two-flop synchronizer, consecutive-sample debounce FSM,
// registered clean level plus one-cycle press/release pulses.
module bttn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic boton,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONF_PRESS = 2'd1,
        PRESSED    = 2'd2,
        CONF_REL   = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          s1_reg, s_reg;
    logic          level_reg, level_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic          p;

    // Normalize polarity so that 1 always means pressed.
    assign p = boton ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg      <= 1'b0;
            s_reg       <= 1'b0;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            s1_reg      <= p;
            s_reg       <= s1_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_reg) begin
                    state_next = CONF_PRESS;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            CONF_PRESS: begin
                if (!s_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s_reg) begin
                    state_next = CONF_REL;
                    cnt_next   = CNT_ONE;
                end
            end
            CONF_REL: begin
                // A single pressed sample sends us back without a pulse.
                if (s_reg) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;

endmodule

// File: tb/tb_bttn_debounce.sv
// Self-checking bench for bttn_debounce: run-length reference model feeding a
// scoreboard queue, a segment table with pulse-count expectations, and latency sequences.
module tb_bttn_debounce;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic boton = 1'b1;
    logic btn_level, btn_press, btn_release;

    bttn_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .boton(boton),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: level toggles once the synchronized sample has disagreed with it
    // for D consecutive edges; any agreeing sample clears the run.
    bit m_s1, m_s, m_level, m_press, m_rel;
    int m_run;
    logic [2:0] exp_q[$];
    bit seen_press;

    task automatic model_edge(input bit r, input bit b);
        if (r) begin
            m_s1 = 0; m_s = 0; m_level = 0; m_press = 0; m_rel = 0; m_run = 0;
        end else begin
            m_press = 0;
            m_rel   = 0;
            if (m_s != m_level) begin
                m_run = m_run + 1;
                if (m_run == D) begin
                    m_level = ~m_level;
                    m_press = m_level;
                    m_rel   = ~m_level;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s  = m_s1;
            m_s1 = ~b;
        end
    endtask

    task automatic step(input bit r, input bit b, output bit pr, output bit rl);
        logic [2:0] got, exp;
        @(negedge clk);
        rst   = r;
        boton = b;
        model_edge(r, b);
        exp_q.push_back({m_level, m_press, m_rel});
        @(posedge clk);
        #1;
        got = {btn_level, btn_press, btn_release};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL sb rst=%0b boton=%0b got lvl/pr/rl=%b expected=%b", r, b, got, exp);
        end
        if (btn_press === 1'b1 || btn_release === 1'b1) begin
            checks++;
            if (btn_press === 1'b1 && btn_release === 1'b1) begin
                errors++;
                $display("FAIL order simultaneous pulses got pr=1 rl=1 expected one");
            end else if (btn_press === 1'b1 && seen_press) begin
                errors++;
                $display("FAIL order press twice got press expected release");
            end else if (btn_release === 1'b1 && !seen_press) begin
                errors++;
                $display("FAIL order release without press got release expected press");
            end
            seen_press = (btn_press === 1'b1);
        end
        if (r) seen_press = 0;
        pr = (btn_press === 1'b1);
        rl = (btn_release === 1'b1);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic reset_idle();
        bit pr, rl;
        for (int i = 0; i < 3; i++) step(1, 1, pr, rl);
        for (int i = 0; i < 4; i++) step(0, 1, pr, rl);
    endtask

    typedef struct {
        bit    r;
        bit    b;
        int    cycles;
        int    exp_press;
        int    exp_rel;
    } seg_t;

    seg_t tbl[14];

    initial begin
        bit pr, rl;
        int np, nr, first;
        bit pat[7];

        tbl[0]  = '{1, 1, 3, 0, 0};   // reset with pin released
        tbl[1]  = '{0, 1, 20, 0, 0};  // idle
        tbl[2]  = '{0, 0, 3, 0, 0};   // short low glitch
        tbl[3]  = '{0, 1, 10, 0, 0};
        for (int k = 0; k < 3; k++) begin
            tbl[4 + 2*k] = '{0, 0, 10, 1, 0};
            tbl[5 + 2*k] = '{0, 1, 10, 0, 1};
        end
        tbl[10] = '{0, 0, 10, 1, 0};
        tbl[11] = '{0, 1, 3, 0, 0};   // short high glitch while pressed
        tbl[12] = '{0, 0, 10, 0, 0};
        tbl[13] = '{0, 1, 10, 0, 1};

        for (int t = 0; t < 14; t++) begin
            np = 0; nr = 0;
            for (int c = 0; c < tbl[t].cycles; c++) begin
                step(tbl[t].r, tbl[t].b, pr, rl);
                np += int'(pr);
                nr += int'(rl);
            end
            check_int($sformatf("seg%0d_press", t), np, tbl[t].exp_press);
            check_int($sformatf("seg%0d_release", t), nr, tbl[t].exp_rel);
        end

        // Clean press: level and pulse after edge D+1 counting from the first low sample.
        reset_idle();
        np = 0; nr = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, pr, rl);
            if (pr && first < 0) first = i;
            np += int'(pr);
            nr += int'(rl);
        end
        check_int("clean_press_edge", first, D + 1);
        check_int("clean_press_count", np, 1);
        check_int("clean_release_count", nr, 0);

        // Bounce: the last uninterrupted low run starts at index 7.
        reset_idle();
        pat[0] = 0; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        pat[4] = 0; pat[5] = 0; pat[6] = 1;
        np = 0; first = -1;
        for (int i = 0; i < 22; i++) begin
            step(0, (i < 7) ? pat[i] : 1'b0, pr, rl);
            if (pr && first < 0) first = i;
            np += int'(pr);
        end
        check_int("bounce_press_edge", first, 7 + D + 1);
        check_int("bounce_press_count", np, 1);

        // Reset mid-confirmation, pin held low through and after reset.
        reset_idle();
        np = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            step((i == 3 || i == 4), 0, pr, rl);
            if (pr && first < 0) first = i;
            np += int'(pr);
        end
        check_int("rst_mid_press_edge", first, 5 + D + 1);
        check_int("rst_mid_press_count", np, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
